mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, meaning the maximum consecutive cycles a loader request waits before it is forced through.
REQ-002 The block SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  meaning the asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have ports p_read, p_write  input  1 each  meaning pipeline MEM-stage read/write strobes.
REQ-005 The block SHALL have ports p_addr, p_wdata  input  8 each  meaning the pipeline address (ALU result) and store data.
REQ-006 The block SHALL have port p_rdata  output  8  meaning combinational read data to the pipeline.
REQ-007 The block SHALL have port p_stall  output  1  meaning the pipeline must hold its MEM-stage access this cycle.
REQ-008 The block SHALL have ports l_req, l_we  input  1 each  meaning loader/debug request and write-enable.
REQ-009 The block SHALL have ports l_addr, l_wdata  input  8 each  meaning the loader address and write data.
REQ-010 The block SHALL have ports l_gnt  output  1 and l_rdata  output  8  meaning registered completion pulse and captured read data.
REQ-011 The block SHALL have ports mem_re, mem_we  output  1 each, mem_addr, mem_wdata  output  8 each, mem_rdata  input  8  meaning the shared 256x8 data memory port (combinational read, write on clk edge).

Function
REQ-012 Pipeline access (p_acc) SHALL be defined as p_read OR p_write; loader access cycle (l_sel) SHALL be the cycle the memory port is driven by the loader.
REQ-013 The FSM SHALL have states IDLE (no loader pending), WAIT (loader blocked) and DONE (l_gnt cycle).
REQ-014 In IDLE or WAIT, l_sel SHALL be 1 when l_req=1 and (p_acc=0 or wait_cnt=STARVE_LIMIT); otherwise the pipeline owns the port.
REQ-015 When the pipeline owns the port: mem_re=p_read, mem_we=p_write, mem_addr=p_addr, mem_wdata=p_wdata, p_stall=0.
REQ-016 When l_sel=1: mem_re=NOT l_we, mem_we=l_we, mem_addr=l_addr, mem_wdata=l_wdata, p_stall=p_acc.
REQ-017 p_rdata SHALL equal mem_rdata in every cycle; its value is only meaningful when p_stall=0.
REQ-018 On an edge with l_sel=1: l_rdata SHALL capture mem_rdata (reads only; holds on writes), l_gnt SHALL be 1 in the next cycle, state SHALL go to DONE, wait_cnt SHALL clear to 0.
REQ-019 In IDLE with l_req=1 and l_sel=0, state SHALL go to WAIT and wait_cnt SHALL be 1 next cycle; in WAIT with l_sel=0, wait_cnt SHALL increment by 1, saturating at STARVE_LIMIT.
REQ-020 In DONE, l_req SHALL be ignored (pipeline owns port, p_stall=0); next state SHALL be IDLE, l_gnt SHALL drop to 0.
REQ-021 l_gnt SHALL be high for exactly one cycle per serviced request.
REQ-022 If l_req falls in WAIT before service, state SHALL return to IDLE, wait_cnt SHALL clear, and no l_gnt SHALL be issued.
REQ-023 A forced loader cycle SHALL stall the pipeline at most one cycle per request; at most one forced stall SHALL occur in any STARVE_LIMIT+2 consecutive cycles.
REQ-024 wait_cnt SHALL be wide enough to hold STARVE_LIMIT without wrap.

Reset
REQ-025 While reset=0: state=IDLE, wait_cnt=0, l_gnt=0, l_rdata=8'h00, regardless of clk.
REQ-026 During reset, mem_we SHALL be 0 and p_stall SHALL be 0; a request pending at reset assertion SHALL be dropped without l_gnt.
REQ-027 After reset deasserts, the first rising edge SHALL behave as from IDLE.

Verification
REQ-028 Idle pipeline, l_req=1, l_we=0, l_addr=8'h10, mem[8'h10]=8'hA5 -> l_sel same cycle, next cycle l_gnt=1, l_rdata=8'hA5, p_stall never 1.
REQ-029 Continuous p_read with l_req=1, l_we=1, l_addr=8'h20, l_wdata=8'h3C, STARVE_LIMIT=3 -> pipeline owns 3 cycles, 4th cycle p_stall=1 and mem[8'h20] written 8'h3C, l_gnt next cycle, p_stall=0 in DONE.
REQ-030 p_write to 8'h05 of 8'h77 with l_req=0 -> mem_we=1, mem_addr=8'h05, mem_wdata=8'h77, p_stall=0, l_gnt=0.
REQ-031 l_req held high after l_gnt with idle pipeline -> DONE cycle ignores it, second access in following cycle, second l_gnt two cycles after the first.
REQ-032 l_req dropped in WAIT after 2 cycles -> IDLE, wait_cnt=0, no l_gnt; new request restarts count from 0.
REQ-033 reset driven 0 mid-WAIT between clock edges -> immediate IDLE, l_gnt=0, l_rdata=8'h00; no memory write occurs.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the pipeline, loader and shared-memory signals around mem_arbiter.
// slave is the arbiter's view; master is the environment (pipeline, loader, RAM).
interface mem_arbiter_if;
   logic       p_read;
   logic       p_write;
   logic [7:0] p_addr;
   logic [7:0] p_wdata;
   logic [7:0] p_rdata;
   logic       p_stall;
   logic       l_req;
   logic       l_we;
   logic [7:0] l_addr;
   logic [7:0] l_wdata;
   logic       l_gnt;
   logic [7:0] l_rdata;
   logic       mem_re;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   modport slave (
      input  p_read, p_write, p_addr, p_wdata,
      output p_rdata, p_stall,
      input  l_req, l_we, l_addr, l_wdata,
      output l_gnt, l_rdata,
      output mem_re, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output p_read, p_write, p_addr, p_wdata,
      input  p_rdata, p_stall,
      output l_req, l_we, l_addr, l_wdata,
      input  l_gnt, l_rdata,
      input  mem_re, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one 256x8 data-memory port between the CPU MEM stage and a loader/debug port.
// The pipeline has priority; a loader waiting STARVE_LIMIT cycles is forced through.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             l_gnt_q;
   logic [7:0]       l_rdata_q;
   logic             p_acc;
   logic             l_sel;

   assign p_acc = bus.p_read | bus.p_write;

   // Reset gates the port so no write or stall can leak out while reset is low.
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      l_sel         = 1'b0;
      bus.mem_re    = bus.p_read;
      bus.mem_we    = bus.p_write & reset;
      bus.mem_addr  = bus.p_addr;
      bus.mem_wdata = bus.p_wdata;
      bus.p_stall   = 1'b0;

      if (reset && (state != DONE) && bus.l_req && (!p_acc || (wait_cnt == CNT_MAX)))
         l_sel = 1'b1;

      if (l_sel) begin
         bus.mem_re    = ~bus.l_we;
         bus.mem_we    = bus.l_we;
         bus.mem_addr  = bus.l_addr;
         bus.mem_wdata = bus.l_wdata;
         bus.p_stall   = p_acc;
      end

      case (state)
         IDLE: begin
            if (l_sel) begin
               state_nxt    = DONE;
               wait_cnt_nxt = '0;
            end else if (bus.l_req) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = CNT_W'(1);
            end
         end
         WAIT: begin
            if (l_sel) begin
               state_nxt    = DONE;
               wait_cnt_nxt = '0;
            end else if (!bus.l_req) begin
               state_nxt    = IDLE;
               wait_cnt_nxt = '0;
            end else if (wait_cnt != CNT_MAX) begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         l_gnt_q   <= 1'b0;
         l_rdata_q <= 8'h00;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         l_gnt_q  <= l_sel;
         if (l_sel && !bus.l_we)
            l_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.p_rdata = bus.mem_rdata;
   assign bus.l_gnt   = l_gnt_q;
   assign bus.l_rdata = l_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 RAM on the memory port.
module tb_mem_arbiter;
   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] mem [256];

   mem_arbiter_if ifc ();

   mem_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ifc.mem_rdata = mem[ifc.mem_addr];
   always @(posedge clk) if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      ifc.p_read = 0; ifc.p_write = 1; ifc.p_addr = 8'h50; ifc.p_wdata = 8'hFF;
      ifc.l_req = 1; ifc.l_we = 1; ifc.l_addr = 8'h50; ifc.l_wdata = 8'hFF;
      #12;
      chk("rst_l_gnt", ifc.l_gnt, 0);
      chk("rst_l_rdata", ifc.l_rdata, 8'h00);
      chk("rst_p_stall", ifc.p_stall, 0);
      chk("rst_mem_we", ifc.mem_we, 0);
      chk("rst_wait_cnt", dut.wait_cnt, 0);

      // pipeline writes preload the RAM
      cyc(); reset = 1; ifc.l_req = 0; ifc.l_we = 0;
      ifc.p_write = 1; ifc.p_addr = 8'h05; ifc.p_wdata = 8'h77; #1;
      chk("pw_mem_we", ifc.mem_we, 1);
      chk("pw_mem_addr", ifc.mem_addr, 8'h05);
      chk("pw_mem_wdata", ifc.mem_wdata, 8'h77);
      chk("pw_p_stall", ifc.p_stall, 0);
      chk("pw_l_gnt", ifc.l_gnt, 0);
      cyc(); ifc.p_addr = 8'h10; ifc.p_wdata = 8'hA5;
      cyc(); ifc.p_addr = 8'h40; ifc.p_wdata = 8'h11;
      cyc(); ifc.p_write = 0; ifc.p_read = 1; ifc.p_addr = 8'h05; #1;
      chk("pr_p_rdata", ifc.p_rdata, 8'h77);
      chk("pr_mem_re", ifc.mem_re, 1);

      // loader read with idle pipeline
      cyc(); ifc.p_read = 0; ifc.l_req = 1; ifc.l_we = 0; ifc.l_addr = 8'h10; #1;
      chk("lr_mem_re", ifc.mem_re, 1);
      chk("lr_mem_addr", ifc.mem_addr, 8'h10);
      chk("lr_mem_we", ifc.mem_we, 0);
      chk("lr_p_stall", ifc.p_stall, 0);
      chk("lr_l_gnt_pre", ifc.l_gnt, 0);
      cyc(); ifc.l_req = 0; #1;
      chk("lr_l_gnt", ifc.l_gnt, 1);
      chk("lr_l_rdata", ifc.l_rdata, 8'hA5);
      chk("lr_p_stall_done", ifc.p_stall, 0);
      cyc(); #1;
      chk("lr_l_gnt_drop", ifc.l_gnt, 0);

      // loader write starved by continuous p_read
      cyc(); ifc.p_read = 1; ifc.p_addr = 8'h05;
      ifc.l_req = 1; ifc.l_we = 1; ifc.l_addr = 8'h20; ifc.l_wdata = 8'h3C; #1;
      chk("st0_p_stall", ifc.p_stall, 0);
      chk("st0_mem_addr", ifc.mem_addr, 8'h05);
      chk("st0_cnt", dut.wait_cnt, 0);
      cyc(); #1;
      chk("st1_p_stall", ifc.p_stall, 0);
      chk("st1_cnt", dut.wait_cnt, 1);
      cyc(); #1;
      chk("st2_p_stall", ifc.p_stall, 0);
      chk("st2_cnt", dut.wait_cnt, 2);
      cyc(); #1;
      chk("st3_cnt", dut.wait_cnt, 3);
      chk("st3_p_stall", ifc.p_stall, 1);
      chk("st3_mem_we", ifc.mem_we, 1);
      chk("st3_mem_re", ifc.mem_re, 0);
      chk("st3_mem_addr", ifc.mem_addr, 8'h20);
      chk("st3_mem_wdata", ifc.mem_wdata, 8'h3C);
      cyc(); ifc.l_req = 0; #1;
      chk("st_done_l_gnt", ifc.l_gnt, 1);
      chk("st_done_p_stall", ifc.p_stall, 0);
      chk("st_done_mem_addr", ifc.mem_addr, 8'h05);
      chk("st_done_l_rdata_hold", ifc.l_rdata, 8'hA5);
      cyc(); ifc.p_addr = 8'h20; #1;
      chk("st_l_gnt_drop", ifc.l_gnt, 0);
      chk("st_mem20", ifc.p_rdata, 8'h3C);

      // l_req held through DONE: back-to-back services
      cyc(); ifc.p_read = 0; ifc.p_addr = 8'h20;
      ifc.l_req = 1; ifc.l_we = 0; ifc.l_addr = 8'h05; #1;
      chk("bb0_mem_addr", ifc.mem_addr, 8'h05);
      chk("bb0_p_stall", ifc.p_stall, 0);
      cyc(); ifc.l_addr = 8'h10; #1;
      chk("bb1_l_gnt", ifc.l_gnt, 1);
      chk("bb1_l_rdata", ifc.l_rdata, 8'h77);
      chk("bb1_mem_addr", ifc.mem_addr, 8'h20);
      chk("bb1_mem_re", ifc.mem_re, 0);
      cyc(); #1;
      chk("bb2_l_gnt", ifc.l_gnt, 0);
      chk("bb2_mem_addr", ifc.mem_addr, 8'h10);
      chk("bb2_mem_re", ifc.mem_re, 1);
      cyc(); ifc.l_req = 0; #1;
      chk("bb3_l_gnt", ifc.l_gnt, 1);
      chk("bb3_l_rdata", ifc.l_rdata, 8'hA5);
      cyc(); #1;
      chk("bb4_l_gnt", ifc.l_gnt, 0);

      // request withdrawn in WAIT, then restarted
      cyc(); ifc.p_read = 1; ifc.p_addr = 8'h05;
      ifc.l_req = 1; ifc.l_we = 1; ifc.l_addr = 8'h30; ifc.l_wdata = 8'h99;
      cyc();
      cyc(); #1;
      chk("wd_cnt2", dut.wait_cnt, 2);
      ifc.l_req = 0; #1;
      chk("wd_p_stall", ifc.p_stall, 0);
      chk("wd_mem_we", ifc.mem_we, 0);
      cyc(); #1;
      chk("wd_cnt_clr", dut.wait_cnt, 0);
      chk("wd_l_gnt", ifc.l_gnt, 0);
      ifc.l_req = 1;
      cyc(); #1;
      chk("wd_re_cnt1", dut.wait_cnt, 1);
      chk("wd_re_stall1", ifc.p_stall, 0);
      cyc(); #1;
      chk("wd_re_cnt2", dut.wait_cnt, 2);
      chk("wd_re_stall2", ifc.p_stall, 0);
      cyc(); #1;
      chk("wd_re_stall3", ifc.p_stall, 1);
      chk("wd_re_mem_addr", ifc.mem_addr, 8'h30);
      cyc(); ifc.l_req = 0; #1;
      chk("wd_re_l_gnt", ifc.l_gnt, 1);
      chk("wd_re_done_stall", ifc.p_stall, 0);

      // asynchronous reset in the middle of WAIT
      cyc(); ifc.p_read = 1; ifc.p_addr = 8'h40;
      ifc.l_req = 1; ifc.l_we = 1; ifc.l_addr = 8'h40; ifc.l_wdata = 8'hEE;
      cyc();
      cyc(); #1;
      chk("ar_cnt_pre", dut.wait_cnt, 2);
      chk("ar_l_rdata_pre", ifc.l_rdata, 8'hA5);
      #2 reset = 1'b0; #1;
      chk("ar_cnt", dut.wait_cnt, 0);
      chk("ar_l_gnt", ifc.l_gnt, 0);
      chk("ar_l_rdata", ifc.l_rdata, 8'h00);
      chk("ar_mem_we", ifc.mem_we, 0);
      chk("ar_p_stall", ifc.p_stall, 0);
      cyc();
      cyc(); #1;
      chk("ar_hold_cnt", dut.wait_cnt, 0);
      chk("ar_hold_l_gnt", ifc.l_gnt, 0);
      cyc(); reset = 1'b1; ifc.l_req = 0; #1;
      chk("ar_no_write", ifc.p_rdata, 8'h11);
      chk("ar_post_l_gnt", ifc.l_gnt, 0);

      // first edge after reset behaves from IDLE
      cyc(); ifc.p_read = 0; ifc.l_req = 1; ifc.l_we = 0; ifc.l_addr = 8'h40; #1;
      chk("pr_l_sel_addr", ifc.mem_addr, 8'h40);
      cyc(); ifc.l_req = 0; #1;
      chk("pr_l_gnt", ifc.l_gnt, 1);
      chk("pr_l_rdata", ifc.l_rdata, 8'h11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
